// File: rtl/rv_pkg.sv
// rv_pkg: shared constants and the fetch queue entry type for the rv front end.
package rv_pkg;
    localparam int DEF_XLEN = 32;
    localparam int INSN_BYTES = 4;
    localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = '0;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_XLEN-1:0] insn;
    } fetch_entry_t;
endpackage

// File: rtl/rv_sync_fifo.sv
// rv_sync_fifo: registered-output synchronous FIFO with flush, full/empty and occupancy count.
module rv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0] count_q, count_d;
    logic push_en, pop_en;

    assign full_o = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign data_o = mem_q[rd_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_en = pop_i && !empty_o;
        push_en = push_i && (!full_o || pop_en);
        mem_d = mem_q;
        if (push_en) mem_d[wr_q] = data_i;
        rd_d = flush_i ? '0 : rd_q + AW'(pop_en);
        wr_d = flush_i ? '0 : wr_q + AW'(push_en);
        count_d = flush_i ? '0 : count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_q <= '{default: '0};
            rd_q <= '0;
            wr_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: sequential instruction prefetch with credit-limited requests, an in-order
// response queue toward decode, and redirect flush that discards in-flight responses.
module rv_fetch_queue
    import rv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            rsp_valid_i,
    input  logic [XLEN-1:0] rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            insn_valid_o,
    input  logic            insn_ready_i,
    output logic [XLEN-1:0] insn_o,
    output logic [XLEN-1:0] insn_pc_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_entry_t rsp_entry, head;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, pc_head;
    logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, occupancy, pc_count;
    logic accept, dropping, q_push, q_pop, q_full, q_empty, pc_full, pc_empty;

    // Queue slots plus in-flight requests never exceed DEPTH, so every response has room.
    assign req_valid_o = rst_i && !redirect_i &&
                         ({1'b0, occupancy} + {1'b0, outstanding_q} < (CW+1)'(DEPTH));
    assign req_addr_o = fetch_pc_q;
    assign accept = req_valid_o && req_ready_i;
    assign dropping = drop_cnt_q != '0;
    assign q_push = rsp_valid_i && !dropping && !redirect_i;
    assign q_pop = insn_valid_o && insn_ready_i && !redirect_i;
    assign insn_valid_o = !q_empty;
    assign insn_o = head.insn;
    assign insn_pc_o = head.pc;
    assign rsp_entry = '{pc: pc_head, insn: rsp_data_i};

    always_comb begin
        fetch_pc_d = redirect_i ? (redirect_pc_i & ~XLEN'(INSN_BYTES - 1))
                   : accept ? fetch_pc_q + XLEN'(INSN_BYTES) : fetch_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_valid_i);
        drop_cnt_d = redirect_i ? outstanding_q - CW'(rsp_valid_i)
                   : drop_cnt_q - CW'(rsp_valid_i && dropping);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    rv_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_insn_q (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_i(q_push), .data_i(rsp_entry), .pop_i(q_pop), .flush_i(redirect_i),
        .data_o(head), .full_o(q_full), .empty_o(q_empty), .count_o(occupancy)
    );

    // Not flushed on redirect: it tracks every in-flight request, stale or not.
    rv_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_i(accept), .data_i(fetch_pc_q), .pop_i(rsp_valid_i), .flush_i(1'b0),
        .data_o(pc_head), .full_o(pc_full), .empty_o(pc_empty), .count_o(pc_count)
    );

    a_rsp_expected: assert property (@(posedge clk_i) disable iff (!rst_i)
        rsp_valid_i |-> outstanding_q != '0);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
        q_push |-> (!q_full || q_pop));
    a_pc_room: assert property (@(posedge clk_i) disable iff (!rst_i)
        accept |-> !pc_full);
    a_pc_aligned: assert property (@(posedge clk_i) disable iff (!rst_i)
        pc_count == outstanding_q && (!rsp_valid_i || !pc_empty));
endmodule

// File: tb/tb_rv_fetch_queue.sv
// tb_rv_fetch_queue: randomized bench; a PC-stream reference model feeds a scoreboard checked by a monitor.
module tb_rv_fetch_queue;
    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk_i = 0, rst_i = 0;
    logic req_valid_o, req_ready_i = 0, rsp_valid_i = 0, redirect_i = 0;
    logic insn_valid_o, insn_ready_i = 0;
    logic [31:0] req_addr_o, rsp_data_i = 0, redirect_pc_i = 0, insn_o, insn_pc_o;

    always #5 clk_i = ~clk_i;

    rv_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i),
        .insn_o(insn_o), .insn_pc_o(insn_pc_o)
    );

    typedef struct {logic [31:0] addr; logic [31:0] pc; int ep; int due;} mreq_t;
    typedef struct {logic [31:0] pc; logic [31:0] insn;} exp_t;

    mreq_t mq[$];
    exp_t sb[$];
    int checks = 0, passed = 0, cyc = 0, epoch = 0, acc_cnt = 0, pops = 0, pops_before = 0;
    int first_acc = -1, first_val = -1;
    int lat_lo = 1, lat_hi = 1, p_rr = 100, p_ir = 100, p_redir = 0;
    logic redir_now = 0, cap_p = 0, cap_a = 0;
    logic [31:0] redir_target = 0, model_pc = RESET_PC, salt = 0, cap_pc = 0, cap_addr = 0;

    function automatic logic [31:0] mem_f(logic [31:0] a);
        return a ^ salt;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        #2;
        if (rst_i && insn_valid_o && insn_ready_i && !redirect_i) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_insn: got pc %h with nothing expected (cycle %0d)", insn_pc_o, cyc);
            end else begin
                e = sb.pop_front();
                chk("insn_pc", insn_pc_o, e.pc);
                chk("insn_data", insn_o, e.insn);
            end
            pops++;
            if (cap_p) begin
                cap_pc = insn_pc_o;
                cap_p = 0;
            end
        end
    end

    task automatic step();
        mreq_t r;
        logic rsp, acc;
        @(negedge clk_i);
        cyc++;
        rsp = 0;
        if (mq.size() != 0) rsp = mq[0].due <= cyc;
        rsp_valid_i = rsp;
        if (rsp) rsp_data_i = mem_f(mq[0].addr);
        else rsp_data_i = $urandom;
        req_ready_i = $urandom_range(99) < p_rr;
        insn_ready_i = $urandom_range(99) < p_ir;
        redirect_i = redir_now || ($urandom_range(999) < p_redir);
        if (redir_now) redirect_pc_i = redir_target;
        else if ($urandom_range(3) == 0) redirect_pc_i = 32'hFFFF_FFF0 | $urandom_range(15);
        else redirect_pc_i = $urandom;
        redir_now = 0;
        #1;
        chk("req_valid", 32'(req_valid_o), 32'(!redirect_i && (sb.size() + mq.size() < DEPTH)));
        chk("insn_valid", 32'(insn_valid_o), 32'(sb.size() != 0));
        if (insn_valid_o && first_val < 0) first_val = cyc;
        acc = req_valid_o && req_ready_i;
        if (rsp) r = mq.pop_front();
        if (redirect_i) begin
            sb.delete();
            epoch++;
            model_pc = redirect_pc_i & ~32'd3;
        end
        if (rsp && r.ep == epoch) sb.push_back('{r.pc, mem_f(r.pc)});
        if (acc) begin
            chk("req_addr", req_addr_o, model_pc);
            mq.push_back('{req_addr_o, model_pc, epoch, cyc + int'($urandom_range(lat_hi, lat_lo))});
            model_pc += 4;
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
            if (cap_a) begin
                cap_addr = req_addr_o;
                cap_a = 0;
            end
            chk("inflight_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
        end
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #3 rst_i = 0;
        #1;
        chk("rst_req_valid", 32'(req_valid_o), 32'd0);
        chk("rst_insn_valid", 32'(insn_valid_o), 32'd0);
        chk("rst_req_addr", req_addr_o, RESET_PC);
        chk("rst_insn", insn_o, 32'd0);
        chk("rst_insn_pc", insn_pc_o, 32'd0);
        mq.delete();
        sb.delete();
        epoch++;
        model_pc = RESET_PC;
        req_ready_i = 0;
        insn_ready_i = 0;
        rsp_valid_i = 0;
        redirect_i = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1;
        acc_cnt = 0;
    endtask

    initial begin
        do_reset();
        // streaming with a 1-cycle memory that returns the address as data
        first_acc = -1;
        first_val = -1;
        repeat (30) step();
        chk("first_insn_latency", 32'(first_val - first_acc), 32'd2);
        chk("stream_accepts", 32'(acc_cnt), 32'd30);

        // decode stalled: credit stops fetch at DEPTH
        do_reset();
        p_ir = 0;
        repeat (12) step();
        chk("fill_accepts", 32'(acc_cnt), 32'd4);
        chk("fill_req_valid", 32'(req_valid_o), 32'd0);
        chk("fill_insn_valid", 32'(insn_valid_o), 32'd1);
        p_ir = 100;
        cap_a = 1;
        repeat (12) step();
        chk("resume_addr", cap_addr, 32'h10);

        // redirect with two requests in flight on a 3-cycle memory
        do_reset();
        lat_lo = 3;
        lat_hi = 3;
        repeat (2) step();
        p_rr = 0;
        redir_now = 1;
        redir_target = 32'h103;
        cap_a = 1;
        cap_p = 1;
        step();
        p_rr = 100;
        repeat (12) step();
        chk("redirect_addr", cap_addr, 32'h100);
        chk("redirect_first_pc", cap_pc, 32'h100);

        // redirect coinciding with a response and a decode handshake at full credit
        do_reset();
        lat_lo = 2;
        lat_hi = 2;
        p_ir = 0;
        repeat (4) step();
        chk("t4_pre_valid", 32'(insn_valid_o), 32'd1);
        p_ir = 100;
        redir_now = 1;
        redir_target = 32'h200;
        cap_a = 1;
        cap_p = 1;
        pops_before = pops;
        step();
        chk("t4_no_pop", 32'(pops - pops_before), 32'd0);
        step();
        chk("t4_valid_after_redirect", 32'(insn_valid_o), 32'd0);
        repeat (10) step();
        chk("t4_first_addr", cap_addr, 32'h200);
        chk("t4_first_pc", cap_pc, 32'h200);

        // random stalls, latencies and redirects
        do_reset();
        salt = $urandom;
        lat_lo = 1;
        lat_hi = 4;
        p_rr = 70;
        p_ir = 60;
        p_redir = 20;
        repeat (2000) step();
        p_redir = 0;
        p_rr = 0;
        p_ir = 100;
        repeat (25) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_valid", 32'(insn_valid_o), 32'd0);

        // asynchronous reset with entries queued
        do_reset();
        salt = 0;
        lat_lo = 1;
        lat_hi = 1;
        p_rr = 100;
        p_ir = 0;
        repeat (4) step();
        chk("t6_queued_valid", 32'(insn_valid_o), 32'd1);
        cap_a = 1;
        do_reset();
        p_ir = 100;
        repeat (6) step();
        chk("t6_first_addr", cap_addr, RESET_PC);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
